// File: rtl/out_port_arbiter_pkg.sv
// out_port_arbiter_pkg
//   Shared constants and types for the router output-port arbiter.
//   PORT / PORT_P1 mirror the router-wide port count (PORT_P1 = number of
//   input ports feeding each output).
//   Optional feature macro: ARB_PKT_LOCK_EN (define for packet-locked
//   wormhole arbitration; leave undefined for flit-level arbitration).
package out_port_arbiter_pkg;

    localparam int PORT    = 4;
    localparam int PORT_P1 = PORT + 1;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/out_port_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Searches (req & mask) starting at
//   index ptr, wrapping modulo NPORT; the first set bit wins.
//   Ports:
//     req   in  NPORT          request vector
//     ptr   in  clog2(NPORT)   highest-priority index
//     mask  in  NPORT          1 = request bit eligible
//     grant out NPORT          one-hot winner (all-zero if none)
//     found out 1              a winner exists
module rr_pick
    import out_port_arbiter_pkg::*;
#(
    parameter int NPORT = PORT_P1
) (
    input  logic [NPORT-1:0]         req,
    input  logic [$clog2(NPORT)-1:0] ptr,
    input  logic [NPORT-1:0]         mask,
    output logic [NPORT-1:0]         grant,
    output logic                     found
);

    localparam int PTR_W = $clog2(NPORT);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= (PTR_W+1)'(NPORT)) begin
                sum = sum - (PTR_W+1)'(NPORT);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx] && mask[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/out_port_arbiter.sv
// out_port_arbiter
//   Per-output-port switch arbiter for the 5-port wormhole router. Picks one
//   requesting input round-robin and drives a registered one-hot crossbar
//   select, holding it until the packet is released.
//   Ports:
//     clk        in  1      router clock
//     rst_       in  1      synchronous active-low reset
//     req        in  NPORT  input i has a head flit routed to this output
//     tail       in  NPORT  input i's head flit is a tail
//     ready      in  1      downstream credit available
//     sel        out NPORT  registered one-hot crossbar select (0 = no grant)
//     xfer       out 1      a flit crosses this output this cycle
//     xfer_tail  out 1      xfer and the flit is a tail
//   Macro ARB_PKT_LOCK_EN: defined -> grant held until the tail transfers;
//   undefined -> every transfer releases the grant (flit-level arbitration).
module out_port_arbiter
    import out_port_arbiter_pkg::*;
#(
    parameter int NPORT   = PORT_P1,
    parameter int RST_PTR = 0
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [NPORT-1:0] req,
    input  logic [NPORT-1:0] tail,
    input  logic             ready,
    output logic [NPORT-1:0] sel,
    output logic             xfer,
    output logic             xfer_tail
);

    localparam int PTR_W = $clog2(NPORT);

    arb_state_t       state_q, state_d;
    logic [NPORT-1:0] sel_q, sel_d;
    logic [PTR_W-1:0] g_q, g_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    logic [NPORT-1:0] tail_eff;
    logic             release_pkt;
    logic [PTR_W-1:0] g_inc;
    logic [PTR_W-1:0] pick_ptr;
    logic [NPORT-1:0] pick_mask;
    logic [NPORT-1:0] win;
    logic             found;

    function automatic logic [PTR_W-1:0] to_idx(input logic [NPORT-1:0] oh);
        logic [PTR_W-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            if (oh[i]) begin
                r = r | PTR_W'(i);
            end
        end
        return r;
    endfunction

`ifdef ARB_PKT_LOCK_EN
    assign tail_eff = tail;
`else
    // Flit-level mode: every flit is treated as a tail, so tail is ignored.
    assign tail_eff = tail | {NPORT{1'b1}};
`endif

    assign sel         = sel_q;
    assign xfer        = (|(sel_q & req)) & ready;
    assign xfer_tail   = xfer & tail_eff[g_q];
    assign release_pkt = (state_q == ARB_LOCKED) && xfer && tail_eff[g_q];
    assign g_inc       = (g_q == PTR_W'(NPORT-1)) ? '0 : g_q + PTR_W'(1);

    // One picker serves both paths: IDLE searches from ptr over all requests;
    // a release searches from g+1 with the releasing input masked off
    // (sel_q is onehot(g) while locked).
    assign pick_ptr  = release_pkt ? g_inc  : ptr_q;
    assign pick_mask = release_pkt ? ~sel_q : '1;

    rr_pick #(
        .NPORT (NPORT)
    ) u_rr_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .grant (win),
        .found (found)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        g_d     = g_q;
        ptr_d   = ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    sel_d   = win;
                    g_d     = to_idx(win);
                    state_d = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                if (release_pkt) begin
                    ptr_d = g_inc;
                    if (found) begin
                        sel_d = win;
                        g_d   = to_idx(win);
                    end else begin
                        sel_d   = '0;
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: begin
                sel_d   = '0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q <= ARB_IDLE;
            sel_q   <= '0;
            g_q     <= '0;
            ptr_q   <= PTR_W'(RST_PTR);
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            g_q     <= g_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: doc/out_port_arbiter.md
# out_port_arbiter

Per-output-port switch arbiter for the 5-port wormhole router. It picks one of the five input ports requesting this output and drives the one-hot `sel` that steers the output crossbar mux (data, valid, VC fields). Each router instantiates one arbiter per output port, between the routing-computation stage and the crossbar.

## Interface
Parameters:
- `NPORT`, 5: number of input ports; must equal `PORT`+1 from `define.h`.
- `RST_PTR`, 0: round-robin pointer value after reset (index of highest-priority input).

Ports:
- `clk`  in  1  router clock.
- `rst_`  in  1  reset; synchronous, active-low.
- `req`  in  NPORT  bit i: input i has a flit at its head routed to this output.
- `tail`  in  NPORT  bit i: input i's head flit is a tail (single-flit packets assert head and tail together).
- `ready`  in  1  downstream can accept a flit this cycle (credit available).
- `sel`  out  NPORT  one-hot crossbar select; all-zero means no grant. Registered.
- `xfer`  out  1  a flit crosses this output this cycle. Combinational: `|(sel & req) & ready`.
- `xfer_tail`  out  1  `xfer` and the transferred flit is a tail.

## Operation
- States: IDLE (`sel`=0) and LOCKED (`sel` one-hot, winner index `g` held in a register).
- **IDLE:**
  - Any `req` bit set: round-robin pick. Search starts at `ptr` and wraps modulo NPORT. The first set bit wins.
  - Next cycle: `sel`=onehot(winner), state LOCKED.
  - `ready` is not required to grant.
- **LOCKED, no transfer:**
  - `sel` holds.
  - If `req[g]` drops (wormhole bubble), the lock is kept; other requesters wait.
- **LOCKED, transfer of a non-tail flit:** `sel` holds.
- **LOCKED, transfer with `tail[g]`=1:**
  - `ptr` ← (g+1) mod NPORT.
  - Same cycle, re-arbitrate from the new `ptr` over `req & ~onehot(g)`.
  - If there is a winner, next-cycle `sel` = new winner and the state stays LOCKED, giving back-to-back packets with no bubble.
  - If there is no winner, go to IDLE.
- `ptr` only advances on packet release, so after a release the previous winner has lowest priority.
- `req` bits not in `sel` never affect `sel` while LOCKED.

## Timing
- Reset values: `sel`=0, state IDLE, `ptr`=RST_PTR, `g`=0. `xfer` and `xfer_tail` are 0 because `sel`=0.
- Grant latency: `req` seen in IDLE at cycle t gives `sel` valid at t+1. The first transfer is possible at t+1 if `ready`.
- Release latency: tail transfer at cycle t gives new `sel` at t+1, so zero dead cycles between packets.
- `ready` low stalls transfers only; the grant is unaffected.
- Reset asserted mid-packet: at the next edge, `sel`=0, IDLE, `ptr`=RST_PTR. Packet recovery is the input buffers' responsibility.
- `req` all-zero for any length of time in IDLE: `sel` stays 0 and `ptr` is unchanged.

## Configuration
- `ARB_PKT_LOCK_EN` defined: packet locking as described above. The grant is held until the tail flit transfers.
- `ARB_PKT_LOCK_EN` not defined: flit-level arbitration (VC-interleaved operation).
  - Every transfer is treated as a release: `tail` is ignored and internally forced to 1.
  - `ptr` advances after each flit.
  - `xfer_tail` equals `xfer`.

## Structure
- Shared constants stay in `define.h`: `PORT`, `PORT_P1`.
- New shared define in `define.h`: `ARB_PKT_LOCK_EN`, commented out by default for the wormhole configuration.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: request vector, pointer, mask.
  - Outputs: one-hot winner and a found flag.
  - Used for both the IDLE path and the release path (one instance fed by a muxed mask).
- State, `g` and `ptr` live in `out_port_arbiter`.

## Test plan
- **Reset and idle:** hold `rst_`=0 for 3 cycles with `req`=5'b11111, then release with `req`=0 → `sel`=0 throughout, `xfer`=0.
- **Single packet, 3 flits from input 2, `ready`=1:**
  - `sel`=5'b00100 one cycle after `req` rises, `xfer` asserted on 3 cycles.
  - Tail on the 3rd flit → IDLE, `sel`=0.
  - Next grant search starts at port 3.
- **Back-to-back release:** input 0 locked, `req`=5'b00011, tail transferred at cycle t → `sel`=5'b00010 at t+1 with no idle cycle.
- **Fairness:** all five inputs continuously send 1-flit packets → grant order 0,1,2,3,4,0… with exactly one `xfer_tail` per cycle after the first grant.
- **Stall and bubble:**
  - Locked on input 1 with `ready`=0 for 4 cycles → `sel` holds, `xfer`=0.
  - `req[1]` drops mid-packet while `req[3]`=1 → `sel` stays 5'b00010 until input 1's tail.
- **Macro off, same two-input stimulus:** `sel` alternates inputs every flit; tail bits are ignored.
